// File: rtl/m14k_dc_mbist_seq_pkg.sv
// Shared encodings for the data-cache March C- BIST sequencer: FSM states,
// march elements, array ids and the per-element direction/background table.
package m14k_dc_mbist_seq_pkg;

    typedef enum logic [1:0] {
        M14K_MBIST_IDLE  = 2'd0,
        M14K_MBIST_RUN   = 2'd1,
        M14K_MBIST_DRAIN = 2'd2,
        M14K_MBIST_DONE  = 2'd3
    } mbist_state_e;

    typedef enum logic [2:0] {
        M14K_MBIST_E0 = 3'd0,
        M14K_MBIST_E1 = 3'd1,
        M14K_MBIST_E2 = 3'd2,
        M14K_MBIST_E3 = 3'd3,
        M14K_MBIST_E4 = 3'd4,
        M14K_MBIST_E5 = 3'd5
    } mbist_elem_e;

    localparam logic [1:0] M14K_MBIST_ARR_TAG  = 2'd0;
    localparam logic [1:0] M14K_MBIST_ARR_WS   = 2'd1;
    localparam logic [1:0] M14K_MBIST_ARR_DATA = 2'd2;

    // Only E3 and E4 sweep downwards.
    function automatic logic m14k_mbist_elem_down(input mbist_elem_e e);
        case (e)
            M14K_MBIST_E3, M14K_MBIST_E4: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic m14k_mbist_elem_two_phase(input mbist_elem_e e);
        case (e)
            M14K_MBIST_E1, M14K_MBIST_E2, M14K_MBIST_E3, M14K_MBIST_E4: return 1'b1;
            default:                                                    return 1'b0;
        endcase
    endfunction

    function automatic logic m14k_mbist_elem_rd_bg(input mbist_elem_e e);
        case (e)
            M14K_MBIST_E2, M14K_MBIST_E4: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic m14k_mbist_elem_wr_bg(input mbist_elem_e e);
        case (e)
            M14K_MBIST_E1, M14K_MBIST_E3: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Lowest unmasked array with id >= lo; bit 2 flags that one was found.
    function automatic logic [2:0] m14k_mbist_find_arr(input logic [2:0] mask, input logic [2:0] lo);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (!mask[i] && (3'(i) >= lo)) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/m14k_dc_mbist_march.sv
// March C- operation generator: element counter, up/down address counter and
// read/write phase bit, presenting the current operation and last-op flag.
module m14k_dc_mbist_march
    import m14k_dc_mbist_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  gclk,
    input  logic                  greset_n,
    input  logic                  init,
    input  logic                  step,
    output logic                  op_wr,
    output logic                  op_pat,
    output logic [ADDR_WIDTH-1:0] op_addr,
    output logic                  last_op
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    mbist_elem_e           elem_r, elem_s, elem_inc_s;
    logic                  phase_r, phase_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s, addr_end_s;

    // Next element/phase/address; the sweep wraps straight into the next element.
    always_comb begin
        elem_s     = elem_r;
        phase_s    = phase_r;
        addr_s     = addr_r;
        elem_inc_s = mbist_elem_e'(elem_r + 3'd1);
        addr_end_s = m14k_mbist_elem_down(elem_r) ? ADDR_ZERO : ADDR_MAX;
        if (init) begin
            elem_s  = M14K_MBIST_E0;
            phase_s = 1'b0;
            addr_s  = ADDR_ZERO;
        end else if (step) begin
            if (m14k_mbist_elem_two_phase(elem_r) && !phase_r) begin
                phase_s = 1'b1;
            end else begin
                phase_s = 1'b0;
                if (addr_r == addr_end_s) begin
                    if (elem_r == M14K_MBIST_E5) begin
                        elem_s = M14K_MBIST_E0;
                        addr_s = ADDR_ZERO;
                    end else begin
                        elem_s = elem_inc_s;
                        addr_s = m14k_mbist_elem_down(elem_inc_s) ? ADDR_MAX : ADDR_ZERO;
                    end
                end else begin
                    addr_s = m14k_mbist_elem_down(elem_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
                end
            end
        end else begin
            elem_s  = elem_r;
            phase_s = phase_r;
            addr_s  = addr_r;
        end
    end

    // Sequence state registers.
    always_ff @(posedge gclk) begin
        if (!greset_n) begin
            elem_r  <= M14K_MBIST_E0;
            phase_r <= 1'b0;
            addr_r  <= ADDR_ZERO;
        end else begin
            elem_r  <= elem_s;
            phase_r <= phase_s;
            addr_r  <= addr_s;
        end
    end

    // Current operation decode: E0 only writes, E5 only reads, others read then write.
    always_comb begin
        op_wr   = (elem_r == M14K_MBIST_E0) || phase_r;
        op_addr = addr_r;
        last_op = (elem_r == M14K_MBIST_E5) && (addr_r == ADDR_MAX);
        if (op_wr) begin
            op_pat = m14k_mbist_elem_wr_bg(elem_r);
        end else begin
            op_pat = m14k_mbist_elem_rd_bg(elem_r);
        end
    end

endmodule

// File: rtl/m14k_dc_mbist_seq.sv
// Data-cache MBIST sequencer: walks tag, WS and data arrays through March C-,
// compares read-back data and captures sticky per-array fails.
module m14k_dc_mbist_seq
    import m14k_dc_mbist_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int TAG_WIDTH  = 24,
    parameter int WS_WIDTH   = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  gclk,
    input  logic                  greset_n,
    input  logic                  bist_start,
    input  logic                  bist_abort,
    input  logic [2:0]            bist_arr_mask,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic [2:0]            bist_fail,
    output logic [ADDR_WIDTH-1:0] bist_fail_addr,
    output logic [1:0]            bist_fail_arr,
    output logic [2:0]            bist_sel,
    output logic                  bist_en,
    output logic                  bist_wr,
    output logic [ADDR_WIDTH-1:0] bist_addr,
    output logic                  bist_wpat,
    input  logic [TAG_WIDTH-1:0]  tag_rdata,
    input  logic [WS_WIDTH-1:0]   ws_rdata,
    input  logic [DATA_WIDTH-1:0] data_rdata
);

    mbist_state_e          state_r, state_s;
    logic [1:0]            arr_r, arr_s;
    logic [2:0]            mask_r;
    logic                  start_q_r, drain_cnt_r;
    logic                  rd_vld_r, rd_exp_r;
    logic [1:0]            rd_arr_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic [2:0]            fail_r;
    logic [ADDR_WIDTH-1:0] fail_addr_r;
    logic [1:0]            fail_arr_r;
    logic                  launch_s, march_init_s, miscmp_s, start_edge_s, run_s;
    logic [2:0]            first_arr_s, next_arr_s;
    logic                  m_wr_s, m_pat_s, m_last_s;
    logic [ADDR_WIDTH-1:0] m_addr_s;

    m14k_dc_mbist_march #(.ADDR_WIDTH(ADDR_WIDTH)) u_march (
        .gclk     (gclk),
        .greset_n (greset_n),
        .init     (march_init_s),
        .step     (run_s),
        .op_wr    (m_wr_s),
        .op_pat   (m_pat_s),
        .op_addr  (m_addr_s),
        .last_op  (m_last_s)
    );

    // FSM next state, launch decode and array hand-over.
    always_comb begin
        state_s      = state_r;
        arr_s        = arr_r;
        launch_s     = 1'b0;
        march_init_s = 1'b0;
        run_s        = (state_r == M14K_MBIST_RUN);
        start_edge_s = bist_start && !start_q_r;
        first_arr_s  = m14k_mbist_find_arr(bist_arr_mask, 3'd0);
        next_arr_s   = m14k_mbist_find_arr(mask_r, {1'b0, arr_r} + 3'd1);
        if (bist_abort) begin
            state_s = M14K_MBIST_IDLE;
        end else begin
            case (state_r)
                M14K_MBIST_IDLE, M14K_MBIST_DONE: begin
                    if (start_edge_s) begin
                        launch_s = 1'b1;
                        if (first_arr_s[2]) begin
                            state_s      = M14K_MBIST_RUN;
                            arr_s        = first_arr_s[1:0];
                            march_init_s = 1'b1;
                        end else begin
                            state_s = M14K_MBIST_DONE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                M14K_MBIST_RUN: begin
                    if (m_last_s) begin
                        state_s = M14K_MBIST_DRAIN;
                    end else begin
                        state_s = M14K_MBIST_RUN;
                    end
                end
                M14K_MBIST_DRAIN: begin
                    if (!drain_cnt_r) begin
                        state_s = M14K_MBIST_DRAIN;
                    end else if (next_arr_s[2]) begin
                        state_s      = M14K_MBIST_RUN;
                        arr_s        = next_arr_s[1:0];
                        march_init_s = 1'b1;
                    end else begin
                        state_s = M14K_MBIST_DONE;
                    end
                end
                default: state_s = M14K_MBIST_IDLE;
            endcase
        end
    end

    // Control registers; the drain counter spans the two-cycle compare tail.
    always_ff @(posedge gclk) begin
        if (!greset_n) begin
            state_r     <= M14K_MBIST_IDLE;
            arr_r       <= M14K_MBIST_ARR_TAG;
            mask_r      <= 3'b000;
            start_q_r   <= 1'b0;
            drain_cnt_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            arr_r       <= arr_s;
            mask_r      <= launch_s ? bist_arr_mask : mask_r;
            start_q_r   <= bist_start;
            drain_cnt_r <= (state_r == M14K_MBIST_DRAIN) ? !drain_cnt_r : 1'b0;
        end
    end

    // Read-back arrives one cycle after the strobe; this tracks what it must equal.
    always_ff @(posedge gclk) begin
        if (!greset_n) begin
            rd_vld_r  <= 1'b0;
            rd_exp_r  <= 1'b0;
            rd_arr_r  <= 2'd0;
            rd_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            rd_vld_r  <= run_s && !m_wr_s && !bist_abort;
            rd_exp_r  <= m_pat_s;
            rd_arr_r  <= arr_r;
            rd_addr_r <= m_addr_s;
        end
    end

    // Compare the returned word against the replicated background.
    always_comb begin
        case (rd_arr_r)
            M14K_MBIST_ARR_TAG:  miscmp_s = rd_vld_r && (tag_rdata  != {TAG_WIDTH{rd_exp_r}});
            M14K_MBIST_ARR_WS:   miscmp_s = rd_vld_r && (ws_rdata   != {WS_WIDTH{rd_exp_r}});
            M14K_MBIST_ARR_DATA: miscmp_s = rd_vld_r && (data_rdata != {DATA_WIDTH{rd_exp_r}});
            default:             miscmp_s = 1'b0;
        endcase
    end

    // Sticky fail capture; address/array are frozen by the first miscompare of a run.
    always_ff @(posedge gclk) begin
        if (!greset_n) begin
            fail_r      <= 3'b000;
            fail_addr_r <= {ADDR_WIDTH{1'b0}};
            fail_arr_r  <= 2'd0;
        end else if (launch_s) begin
            fail_r      <= 3'b000;
            fail_addr_r <= {ADDR_WIDTH{1'b0}};
            fail_arr_r  <= 2'd0;
        end else if (miscmp_s) begin
            fail_r[rd_arr_r] <= 1'b1;
            if (fail_r == 3'b000) begin
                fail_addr_r <= rd_addr_r;
                fail_arr_r  <= rd_arr_r;
            end
        end
    end

    // Array-side bus is idle outside RUN so functional access owns the arrays.
    always_comb begin
        bist_busy      = (state_r == M14K_MBIST_RUN) || (state_r == M14K_MBIST_DRAIN);
        bist_done      = (state_r == M14K_MBIST_DONE);
        bist_fail      = fail_r;
        bist_fail_addr = fail_addr_r;
        bist_fail_arr  = fail_arr_r;
        if (run_s) begin
            bist_sel  = 3'b001 << arr_r;
            bist_en   = 1'b1;
            bist_wr   = m_wr_s;
            bist_addr = m_addr_s;
            bist_wpat = m_wr_s && m_pat_s;
        end else begin
            bist_sel  = 3'b000;
            bist_en   = 1'b0;
            bist_wr   = 1'b0;
            bist_addr = {ADDR_WIDTH{1'b0}};
            bist_wpat = 1'b0;
        end
    end

endmodule
